mux2_4: RTL and testbench
=========================

// Module: mux2_4
// PURPOSE
//   Two-input, WIDTH-bit (default 4) multiplexer with one registered output stage.
//   Selects operand a (sel=0) or operand b (sel=1) and presents the result on out.
//   Serves as the datapath-select primitive for the project's ALU/datapath blocks.
//   A simple valid/ready handshake allows it to sit inside a back-pressured pipeline.
// PARAMETERS
//   WIDTH    4   bit width of a, b and out
//   OUT_REG  1   1: out registered (1-cycle latency); 0: out combinational (0 latency)
// PORTS
//   clk        in   1      rising-edge clock; the block's only clock
//   rst        in   1      asynchronous, active-high reset
//   a          in   WIDTH  operand 0, selected when sel=0
//   b          in   WIDTH  operand 1, selected when sel=1
//   sel        in   1      select: 0 -> a, 1 -> b
//   in_valid   in   1      a/b/sel are valid this cycle
//   in_ready   out  1      stage can accept an input this cycle
//   out        out  WIDTH  selected operand
//   out_valid  out  1      out holds a valid result
//   out_ready  in   1      downstream accepts out this cycle
// BEHAVIOUR
//   - Selection: mux_val = sel ? b : a, bit-exact over WIDTH bits; no arithmetic.
//   - Reset: rst=1 forces out=0 and out_valid=0 immediately, independent of clk.
//     Releasing rst leaves out=0 and out_valid=0 until the first accepted input.
//   - OUT_REG=1:
//     * in_ready = ~out_valid | out_ready (single-entry stage, full-throughput).
//     * Accept when in_valid & in_ready at rising clk: out <= mux_val, out_valid <= 1.
//     * Output consumed (out_valid & out_ready) with no new accept: out_valid <= 0.
//       out keeps its last value (no clearing).
//     * out_valid & ~out_ready: out and out_valid hold; inputs are ignored (in_ready=0).
//     * Simultaneous consume and accept: out takes the new value; out_valid stays 1.
//     * Latency: exactly 1 clk from accept to out_valid.
//   - OUT_REG=0:
//     * out = mux_val and out_valid = in_valid combinationally; in_ready = out_ready.
//     * rst still forces out_valid=0 and out=0 while asserted.
//   - X on sel while in_valid=1 is illegal.
//     With in_valid=0, sel/a/b values do not affect any output.
//   - Reset mid-transfer discards the held result; no partial state survives.
// TESTING
//   1. rst=1 for 100 ns, a=0, b=0, sel=1 -> out=4'h0, out_valid=0 during and after reset.
//   2. a=4'h0, b=4'hF, sel=1, in_valid=1, out_ready=1 -> next clk out=4'hF, out_valid=1.
//   3. a=4'hA, b=4'h5, sel=0, accepted -> out=4'hA.
//      Flip sel=1 in the next accepted cycle -> out=4'h5.
//   4. out_ready=0 with out_valid=1, then new a/b/sel applied -> in_ready=0;
//      out holds the old value for 3 clks.
//      Raising out_ready -> next input is accepted on that same edge.
//   5. Assert rst asynchronously mid-stream with out_valid=1 -> out=0, out_valid=0
//      before the next clk edge.
//   6. Exhaustive: all 16x16x2 a/b/sel combinations back-to-back, out_ready=1
//      -> every result equals sel?b:a one clk later, no bubbles.

Source files
------------

// File: rtl/mux2_4.sv
// Two-input WIDTH-bit select with an optional single-entry output register
// and a valid/ready handshake for use inside back-pressured pipelines.
module mux2_4 #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mux_val;

  // Bit-exact operand select
  always_comb begin
    mux_val = a;
    if (sel) mux_val = b;
  end

  if (OUT_REG != 0) begin : g_reg

    logic [WIDTH-1:0] out_q;
    logic             valid_q;
    logic             accept;

    // Stage is free when empty or when its current result leaves this cycle
    assign in_ready = ~valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    // Output register: load on accept, drop valid on consume, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else if (accept) begin
        out_q   <= mux_val;
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

  end else begin : g_comb

    // Pass-through; reset still blanks the output while asserted
    always_comb begin
      out       = mux_val;
      out_valid = in_valid;
      if (rst) begin
        out       = '0;
        out_valid = 1'b0;
      end
    end

    assign in_ready = out_ready;

  end

  // An unknown select on a valid input cannot produce a defined result
  a_sel_known : assert property (@(posedge clk) disable iff (rst)
    in_valid |-> !$isunknown(sel));

endmodule

// File: tb/tb_mux2_4.sv
// Scoreboard bench for mux2_4 (registered output): driver pushes expected
// results on accept, monitor pops and compares on every output handshake.
module tb_mux2_4;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         sel, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] out;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb[$];
  logic         exp_v = 1'b0;

  mux2_4 #(.WIDTH(W), .OUT_REG(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; checks handshake against the bench model at negedge
  task automatic cycle(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input logic tiv, input logic tord);
    logic exp_rdy;
    @(posedge clk);
    #1;
    a = ta; b = tb; sel = ts; in_valid = tiv; out_ready = tord;
    @(negedge clk);
    exp_rdy = ~exp_v | tord;
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (tiv && exp_rdy) begin
      sb.push_back(ts ? tb : ta);
      exp_v = 1'b1;
    end else if (tord) begin
      exp_v = 1'b0;
    end
  endtask

  // Monitor: every output transfer must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected none at %0t", out, $time);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        checks++;
        if (out !== e) begin
          errors++;
          $display("FAIL out_data: got %0h expected %0h at %0t", out, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    rst = 1'b1; a = '0; b = '0; sel = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    repeat (10) @(posedge clk);
    #1;
    chk("rst_hold_out", 32'(out), 32'h0);
    chk("rst_hold_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    cycle(4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("post_rst_out", 32'(out), 32'h0);
    cycle(4'h3, 4'h9, 1'b0, 1'b0, 1'b1);
    chk("idle_out", 32'(out), 32'h0);

    // 2: first accept selects b
    cycle(4'h0, 4'hF, 1'b1, 1'b1, 1'b1);
    // 3: select a, then b, back to back
    cycle(4'hA, 4'h5, 1'b0, 1'b1, 1'b1);
    cycle(4'hA, 4'h5, 1'b1, 1'b1, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

    // 4: back-pressure holds 4'h3 for three clocks, release accepts same edge
    cycle(4'h3, 4'hC, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'h6, 4'h9, 1'b1, 1'b1, 1'b0);
      chk("hold_out", 32'(out), 32'h3);
    end
    cycle(4'h6, 4'h9, 1'b1, 1'b1, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("after_hold_out", 32'(out), 32'h9);

    // 5: asynchronous reset while a result is held
    cycle(4'h7, 4'h1, 1'b0, 1'b1, 1'b1);
    cycle(4'h2, 4'h4, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    sb.delete();
    exp_v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("post_async_out", 32'(out), 32'h0);

    // 6: exhaustive back-to-back, no bubbles
    for (int s = 0; s < 2; s++)
      for (int ia = 0; ia < 16; ia++)
        for (int ib = 0; ib < 16; ib++)
          cycle(4'(ia), 4'(ib), 1'(s), 1'b1, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
